// File: rtl/uart_tx_8bit.sv
// uart_tx_8bit
//   8N1 serial transmitter: a single-byte holding register that sits in front
//   of the shift register, so a second byte can be queued while a frame is on
//   the line. Each serial bit lasts CLKS_PER_BIT cycles. A frame is one start
//   bit (0), the data bits LSB first, and one stop bit (1).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit, 1..65535
//
// Ports
//   clk    in   sole clock, rising edge
//   clear  in   synchronous active-high reset; overrides load and any transfer
//   D      in   [7:0] byte to transmit
//   load   in   write strobe; D is captured when load=1 and ready=1
//   ready  out  holding register empty (combinational ~hold_full)
//   tx     out  registered serial line, idle high
//   busy   out  a frame (START/DATA/STOP) is on tx
//   done   out  one-cycle pulse in the cycle after a frame's stop bit ends
module uart_tx_8bit #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] D,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [2:0]  idx_q,       idx_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  hold_q,      hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_q,        tx_d;
  logic        done_q,      done_d;

  logic load_accept;
  logic bit_end;

  assign ready = ~hold_full_q;
  assign tx    = tx_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  // A load is only taken while the holding register is empty. A transfer
  // needs hold_full_q=1, so a load and a transfer can never coincide.
  assign load_accept = load & ~hold_full_q;
  assign bit_end     = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    done_d      = 1'b0;

    if (load_accept) begin
      hold_d      = D;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // The shift register is consumed LSB first: the bit now on tx is
      // shift_q[0], so the next one to drive is shift_q[1] before shifting.
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // A queued byte goes straight into a new start bit with no idle gap.
      STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          idx_d  = '0;
          done_d = 1'b1;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_8bit.sv
module tb_uart_tx_8bit;

  logic       clk;
  logic       clear, load, ready, tx, busy, done;
  logic [7:0] D;
  logic       clear1, load1, ready1, tx1, busy1, done1;
  logic [7:0] D1;

  int unsigned checks;
  int unsigned errors;

  uart_tx_8bit #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .clear (clear),
    .D     (D),
    .load  (load),
    .ready (ready),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  uart_tx_8bit #(.CLKS_PER_BIT(1)) dut1 (
    .clk   (clk),
    .clear (clear1),
    .D     (D1),
    .load  (load1),
    .ready (ready1),
    .tx    (tx1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit period n of a frame carrying b:
  // 0 = start, 1..8 = b[0]..b[7], 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned n);
    if (n == 0) return 1'b0;
    if (n >= 9) return 1'b1;
    return b[3'(n - 1)];
  endfunction

  // {tx, busy, ready, done} after each edge.
  task automatic test_reset();
    logic [3:0] got;
    clear  = 1'b1;
    clear1 = 1'b1;
    load   = 1'b0;
    load1  = 1'b0;
    D      = 8'h00;
    D1     = 8'h00;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      got = {tx, busy, ready, done};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL reset c=%0d got tx/busy/ready/done=%b exp 1010", c, got);
      end
      got = {tx1, busy1, ready1, done1};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL reset_fast c=%0d got tx/busy/ready/done=%b exp 1010", c, got);
      end
    end
    clear  = 1'b0;
    clear1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      got = {tx, busy, ready, done};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL idle c=%0d got tx/busy/ready/done=%b exp 1010", c, got);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] got, exp;
    for (int c = 1; c <= 50; c++) begin
      load = (c == 1);
      // D wanders after capture; the frame must not follow it.
      D    = (c == 1) ? 8'hA5 : 8'(c * 37);
      @(posedge clk); #1;
      if (c == 1)       exp = 4'b1000;
      else if (c <= 41) exp = {frame_bit(8'hA5, 32'((c - 2) / 4)), 3'b110};
      else if (c == 42) exp = 4'b1011;
      else              exp = 4'b1010;
      got = {tx, busy, ready, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL frame_a5 c=%0d got tx/busy/ready/done=%b exp %b", c, got, exp);
      end
    end
    load = 1'b0;
  endtask

  // 00 then FF queued 10 cycles later; 55 offered while the queue is full and
  // 77 offered on the exact transfer edge must both be dropped.
  task automatic test_back_to_back();
    logic [3:0] got, exp;
    logic       rdy;
    for (int c = 1; c <= 110; c++) begin
      load = (c == 1) || (c == 11) || (c == 21) || (c == 42);
      case (c)
        1:       D = 8'h00;
        11:      D = 8'hFF;
        21:      D = 8'h55;
        42:      D = 8'h77;
        default: D = 8'(c ^ 8'h5A);
      endcase
      @(posedge clk); #1;
      rdy = !((c == 1) || (c >= 11 && c <= 41));
      if (c == 1)       exp = {3'b100, 1'b0};
      else if (c <= 41) exp = {frame_bit(8'h00, 32'((c - 2) / 4)), 1'b1, rdy, 1'b0};
      else if (c <= 81) exp = {frame_bit(8'hFF, 32'((c - 42) / 4)), 1'b1, rdy, (c == 42)};
      else              exp = {2'b10, rdy, (c == 82)};
      got = {tx, busy, ready, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b c=%0d got tx/busy/ready/done=%b exp %b", c, got, exp);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_clear_abort();
    logic [3:0] got, exp;
    for (int c = 1; c <= 60; c++) begin
      load  = (c == 1) || (c == 20);
      D     = (c == 1) ? 8'hA5 : 8'hEE;
      clear = (c == 20);
      @(posedge clk); #1;
      if (c == 1)       exp = 4'b1000;
      else if (c <= 19) exp = {frame_bit(8'hA5, 32'((c - 2) / 4)), 3'b110};
      else              exp = 4'b1010;
      got = {tx, busy, ready, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort c=%0d got tx/busy/ready/done=%b exp %b", c, got, exp);
      end
    end
    clear = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      load = (c == 1);
      D    = (c == 1) ? 8'h01 : 8'hC3;
      @(posedge clk); #1;
      if (c == 1)       exp = 4'b1000;
      else if (c <= 41) exp = {frame_bit(8'h01, 32'((c - 2) / 4)), 3'b110};
      else if (c == 42) exp = 4'b1011;
      else              exp = 4'b1010;
      got = {tx, busy, ready, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL after_abort c=%0d got tx/busy/ready/done=%b exp %b", c, got, exp);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_fast_clk();
    logic [3:0] got, exp;
    logic       seq [0:9];
    seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 1; c <= 14; c++) begin
      load1 = (c == 1);
      D1    = (c == 1) ? 8'h3C : 8'h00;
      @(posedge clk); #1;
      if (c == 1)       exp = 4'b1000;
      else if (c <= 11) exp = {seq[c - 2], 3'b110};
      else if (c == 12) exp = 4'b1011;
      else              exp = 4'b1010;
      got = {tx1, busy1, ready1, done1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fast_3c c=%0d got tx/busy/ready/done=%b exp %b", c, got, exp);
      end
    end
    load1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    clear1 = 1'b1;
    load   = 1'b0;
    load1  = 1'b0;
    D      = 8'h00;
    D1     = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_clear_abort();
    test_fast_clk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_8bit.md
UART_TX_8BIT -- requirements
Module: uart_tx_8bit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  synchronous, active-high reset.
REQ-004 D  input  8  parallel byte to transmit.
REQ-005 load  input  1  write strobe; D captured when load=1 and ready=1 at a rising edge.
REQ-006 ready  output  1  1 = holding register empty, byte acceptable.
REQ-007 tx  output  1  registered serial line, idle high.
REQ-008 busy  output  1  1 while a frame is on tx (START, DATA, STOP).
REQ-009 done  output  1  one-cycle pulse at end of each completed frame.

Function
REQ-010 Storage SHALL be one 8-bit holding register (hold, hold_full) plus one 8-bit shift register; ready SHALL equal ~hold_full combinationally.
REQ-011 load=1 with ready=1 at edge k SHALL set hold=D, hold_full=1 at edge k.
REQ-012 load=1 with ready=0 SHALL be ignored: no state change, byte dropped.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; busy=1 in START/DATA/STOP.
REQ-014 IDLE with hold_full=1 at edge k+1 SHALL copy hold into shift register, clear hold_full, enter START; tx=0 from edge k+1 (load-to-start-bit latency 1 cycle).
REQ-015 Bit counter SHALL count 0..CLKS_PER_BIT-1; each serial bit SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-016 Frame SHALL be start bit 0, D[0]..D[7] (LSB first), stop bit 1; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-017 Bit index in DATA SHALL count 0..7; after bit 7 period SHALL enter STOP.
REQ-018 At end of STOP period done SHALL be 1 for exactly the next cycle.
REQ-019 At end of STOP with hold_full=1 SHALL transfer hold and enter START directly (no idle gap, tx=0 immediately); otherwise SHALL enter IDLE with tx=1.
REQ-020 A load accepted during a frame SHALL be held until REQ-019 transfer; ready SHALL return to 1 the cycle after transfer.
REQ-021 A load in the same cycle as a transfer SHALL be refused (ready=0 that cycle).
REQ-022 D changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-023 clear=1 at an edge SHALL force state=IDLE, tx=1, busy=0, done=0, hold_full=0 (ready=1), counters 0.
REQ-024 clear SHALL take priority over load and any transfer; clear mid-frame SHALL abort it with no done pulse.
REQ-025 Outputs before first clear are undefined; bench SHALL apply clear for at least 2 cycles.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-026 clear 2 cycles, then idle 20 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
REQ-027 load D=8'hA5 one cycle -> tx: 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4; busy=1 for 40 cycles; done=1 one cycle after; tx=1.
REQ-028 load 8'h00, then load 8'hFF 10 cycles later -> ready=0 from second load until second transfer; second start bit immediately follows first stop bit; two done pulses 40 cycles apart.
REQ-029 with hold_full=1, third load 8'h55 -> ignored; exactly two frames transmitted, no 8'h55 on tx.
REQ-030 clear asserted during data bit 3 of 8'hA5 -> next edge tx=1, busy=0, ready=1; no done pulse; subsequent load 8'h01 transmits a clean full frame.
REQ-031 CLKS_PER_BIT=1, load 8'h3C -> tx = 0,0,0,1,1,1,1,0,0,1 on 10 consecutive cycles; done on cycle 11.
